// File: rtl/nb_info_rw_if.sv
// Bundle of the PU-side handshake and line-RAM bus for the neighbour-info sequencer.
interface nb_info_rw_if #(
  parameter int addr_bits = 6,
  parameter int data_bits = 8
);
  // PU parser / predictor side
  logic                 start;
  logic [addr_bits-1:0] pu_x;
  logic [addr_bits:0]   pu_w;
  logic                 commit;
  logic [data_bits-1:0] cur_info;
  logic                 busy;
  logic                 nb_valid;
  logic [data_bits-1:0] up_info;
  logic [data_bits-1:0] upright_info;
  logic                 upright_avail;
  logic                 done;
  // line RAM side
  logic                 ram_en;
  logic                 ram_we;
  logic [addr_bits-1:0] ram_a;
  logic [addr_bits-1:0] ram_dpra;
  logic [data_bits-1:0] ram_d;
  logic [data_bits-1:0] ram_spo;
  logic [data_bits-1:0] ram_dpo;

  // slave: the sequencer itself
  modport slave (
    input  start, pu_x, pu_w, commit, cur_info, ram_spo, ram_dpo,
    output busy, nb_valid, up_info, upright_info, upright_avail, done,
           ram_en, ram_we, ram_a, ram_dpra, ram_d
  );

  // master: whoever drives PUs and owns the RAM
  modport master (
    output start, pu_x, pu_w, commit, cur_info, ram_spo, ram_dpo,
    input  busy, nb_valid, up_info, upright_info, upright_avail, done,
           ram_en, ram_we, ram_a, ram_dpra, ram_d
  );
endinterface

// File: rtl/nb_info_rw.sv
// Neighbour-info line-RAM sequencer: reads the above and above-right entries for a PU,
// holds them for prediction, then writes the PU's own info over its width on commit.
//
// Handshake: start is a single-cycle request honoured only in IDLE with pu_w != 0;
// commit is a single-cycle request honoured only while nb_valid is high. Requests seen
// in any other state are dropped, never queued. done pulses for exactly one cycle.
module nb_info_rw #(
  parameter int addr_bits = 6,
  parameter int data_bits = 8
) (
  input  logic         clk,
  input  logic         rst,
  nb_info_rw_if.slave  bus,
  output logic [2:0]   dbg_state
);

  localparam logic [addr_bits:0] depth = {1'b1, {addr_bits{1'b0}}};

  typedef enum logic [2:0] {
    s_idle     = 3'd0,
    s_read     = 3'd1,
    s_nb_ready = 3'd2,
    s_write    = 3'd3,
    s_done     = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [addr_bits-1:0] px;
  logic [addr_bits:0]   pw;
  logic [data_bits-1:0] info;
  logic [addr_bits-1:0] wr_ptr;
  logic [addr_bits:0]   count;
  logic [data_bits-1:0] up_q;
  logic [data_bits-1:0] upright_q;
  logic                 avail_q;

  // Above-right column, kept one bit wider so running off the line is detectable.
  logic [addr_bits:0]   ur_sum;
  logic                 ur_avail;
  logic [addr_bits:0]   space;
  logic [addr_bits:0]   wr_count;

  assign ur_sum   = {1'b0, px} + pw;
  assign ur_avail = (ur_sum < depth);
  // Writes never wrap: clip the run at the end of the line.
  assign space    = depth - {1'b0, px};
  assign wr_count = (pw < space) ? pw : space;

  assign dbg_state = state;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= s_idle;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      s_idle:     if (bus.start && (bus.pu_w != '0)) state_nxt = s_read;
      s_read:     state_nxt = s_nb_ready;
      s_nb_ready: if (bus.commit) state_nxt = s_write;
      s_write:    if (count == {{addr_bits{1'b0}}, 1'b1}) state_nxt = s_done;
      s_done:     state_nxt = s_idle;
      default:    state_nxt = s_idle;
    endcase
  end

  // PU parameters, neighbour results and write-run bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      px        <= '0;
      pw        <= '0;
      info      <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      up_q      <= '0;
      upright_q <= '0;
      avail_q   <= 1'b0;
    end else begin
      case (state)
        s_idle: begin
          if (bus.start && (bus.pu_w != '0)) begin
            px <= bus.pu_x;
            pw <= bus.pu_w;
          end
        end
        s_read: begin
          up_q      <= bus.ram_spo;
          upright_q <= ur_avail ? bus.ram_dpo : '0;
          avail_q   <= ur_avail;
        end
        s_nb_ready: begin
          if (bus.commit) begin
            info   <= bus.cur_info;
            wr_ptr <= px;
            count  <= wr_count;
          end
        end
        s_write: begin
          wr_ptr <= wr_ptr + 1'b1;
          count  <= count - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Output decode from state; RAM bus is quiet outside READ and WRITE.
  always_comb begin
    bus.busy     = (state != s_idle);
    bus.nb_valid = 1'b0;
    bus.done     = 1'b0;
    bus.ram_en   = 1'b0;
    bus.ram_we   = 1'b0;
    bus.ram_a    = '0;
    bus.ram_dpra = '0;
    bus.ram_d    = '0;
    case (state)
      s_read: begin
        bus.ram_en   = 1'b1;
        bus.ram_a    = px;
        bus.ram_dpra = ur_sum[addr_bits-1:0];
      end
      s_nb_ready: bus.nb_valid = 1'b1;
      s_write: begin
        bus.ram_en   = 1'b1;
        bus.ram_we   = 1'b1;
        bus.ram_dpra = wr_ptr;
        bus.ram_d    = info;
      end
      s_done:  bus.done = 1'b1;
      default: ;
    endcase
  end

  assign bus.up_info       = up_q;
  assign bus.upright_info  = upright_q;
  assign bus.upright_avail = avail_q;

endmodule

// File: tb/tb_nb_info_rw.sv
// Bench for nb_info_rw: line-RAM model, table of PU vectors, hand sequences for
// ignored requests, reset mid-write and back-to-back PUs; RAM writes checked
// against an expected queue.
module tb_nb_info_rw;

  localparam int ab = 6;
  localparam int db = 8;
  localparam int depth = 1 << ab;

  logic       clk;
  logic       rst;
  logic       preload;
  logic [2:0] dbg_state;

  nb_info_rw_if #(.addr_bits(ab), .data_bits(db)) bus ();

  nb_info_rw #(.addr_bits(ab), .data_bits(db)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- line RAM model ----------------
  logic [db-1:0] mem     [depth];
  logic [db-1:0] ref_mem [depth];

  assign bus.ram_spo = mem[bus.ram_a];
  assign bus.ram_dpo = mem[bus.ram_dpra];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < depth; i++) mem[i] <= 8'(i);
    end else if (bus.ram_en && bus.ram_we) begin
      mem[bus.ram_dpra] <= bus.ram_d;
    end
  end

  // ---------------- scoreboard ----------------
  int n_pass  = 0;
  int n_total = 0;
  logic [ab+db-1:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Each write cycle is seen once, mid-cycle.
  always @(negedge clk) begin
    if (!rst && bus.ram_en && bus.ram_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", int'({bus.ram_dpra, bus.ram_d}), -1);
      end else begin
        check("ram_write", int'({bus.ram_dpra, bus.ram_d}), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic push_writes(input int x, input int n, input logic [db-1:0] info);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({6'(x + i), info});
      ref_mem[x + i] = info;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ram();
    int bad;
    bad = 0;
    for (int i = 0; i < depth; i++) if (mem[i] !== ref_mem[i]) bad++;
    check("ram_contents_bad_entries", bad, 0);
  endtask

  // Start a PU from IDLE and check the READ cycle and neighbour results.
  task automatic start_pu(input int x, input int w, input int up, input int ur, input int av);
    tick();
    check("idle_busy", int'(bus.busy), 0);
    check("idle_done", int'(bus.done), 0);
    bus.start = 1'b1;
    bus.pu_x  = 6'(x);
    bus.pu_w  = 7'(w);
    tick();
    bus.start = 1'b0;
    check("read_busy", int'(bus.busy), 1);
    check("read_nb_valid", int'(bus.nb_valid), 0);
    check("read_ram_en", int'(bus.ram_en), 1);
    check("read_ram_we", int'(bus.ram_we), 0);
    check("read_ram_a", int'(bus.ram_a), x);
    check("read_ram_dpra", int'(bus.ram_dpra), (x + w) % depth);
    tick();
    check("nb_valid", int'(bus.nb_valid), 1);
    check("up_info", int'(bus.up_info), up);
    check("upright_info", int'(bus.upright_info), ur);
    check("upright_avail", int'(bus.upright_avail), av);
  endtask

  // Commit and wait for done; n is the expected number of writes.
  task automatic commit_pu(input int x, input int n, input logic [db-1:0] info);
    int cyc;
    bus.commit   = 1'b1;
    bus.cur_info = info;
    push_writes(x, n, info);
    tick();
    bus.commit = 1'b0;
    check("write_nb_valid", int'(bus.nb_valid), 0);
    cyc = 0;
    while (!bus.done && cyc < 200) begin
      tick();
      cyc++;
    end
    check("done_seen", int'(bus.done), 1);
    check("done_latency", cyc, n);
    check("pending_writes", exp_q.size(), 0);
    check_ram();
  endtask

  task automatic run_pu(input int x, input int w, input logic [db-1:0] info,
                        input int up, input int ur, input int av, input int n);
    start_pu(x, w, up, ur, av);
    commit_pu(x, n, info);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    int x;
    int w;
    logic [db-1:0] info;
    int up;
    int ur;
    int av;
    int nwr;
  } vec_t;

  vec_t vecs[5];

  initial begin
    // RAM starts as RAM[i]=i; each row sees the writes of the rows before it.
    vecs[0] = '{x: 4,  w: 2,  info: 8'hA5, up: 8'h04, ur: 8'h06, av: 1, nwr: 2};
    vecs[1] = '{x: 60, w: 8,  info: 8'h3C, up: 8'h3C, ur: 8'h00, av: 0, nwr: 4};
    vecs[2] = '{x: 3,  w: 1,  info: 8'h77, up: 8'h03, ur: 8'hA5, av: 1, nwr: 1};
    vecs[3] = '{x: 0,  w: 64, info: 8'h01, up: 8'h00, ur: 8'h00, av: 0, nwr: 64};
    vecs[4] = '{x: 62, w: 1,  info: 8'h5A, up: 8'h01, ur: 8'h01, av: 1, nwr: 1};

    for (int i = 0; i < depth; i++) ref_mem[i] = 8'(i);
    bus.start    = 1'b0;
    bus.pu_x     = '0;
    bus.pu_w     = '0;
    bus.commit   = 1'b0;
    bus.cur_info = '0;
    preload      = 1'b1;
    rst          = 1'b1;
    repeat (3) tick();

    // Reset state
    check("rst_busy", int'(bus.busy), 0);
    check("rst_nb_valid", int'(bus.nb_valid), 0);
    check("rst_outputs", int'({bus.up_info, bus.upright_info, bus.upright_avail, bus.done}), 0);
    check("rst_ram_bus", int'({bus.ram_en, bus.ram_we, bus.ram_a, bus.ram_dpra, bus.ram_d}), 0);
    preload = 1'b0;
    rst     = 1'b0;
    tick();
    check_ram();

    // Table-driven PUs
    foreach (vecs[i]) begin
      run_pu(vecs[i].x, vecs[i].w, vecs[i].info, vecs[i].up, vecs[i].ur, vecs[i].av, vecs[i].nwr);
    end

    // Zero-width start is ignored
    tick();
    bus.start = 1'b1;
    bus.pu_x  = 6'd5;
    bus.pu_w  = 7'd0;
    tick();
    bus.start = 1'b0;
    check("zero_width_busy", int'(bus.busy), 0);
    tick();
    check("zero_width_busy_later", int'(bus.busy), 0);

    // Requests outside their accepting state are dropped
    bus.start = 1'b1;
    bus.pu_x  = 6'd10;
    bus.pu_w  = 7'd2;
    tick();
    bus.start    = 1'b0;
    bus.commit   = 1'b1;               // in READ: ignored
    bus.cur_info = 8'hEE;
    tick();
    bus.commit = 1'b0;
    check("commit_in_read_nb_valid", int'(bus.nb_valid), 1);
    check("commit_in_read_up", int'(bus.up_info), int'(ref_mem[10]));
    bus.start = 1'b1;                  // in NB_READY alone: ignored
    bus.pu_x  = 6'd20;
    bus.pu_w  = 7'd3;
    tick();
    bus.start = 1'b0;
    check("start_in_ready_nb_valid", int'(bus.nb_valid), 1);
    check("start_in_ready_up", int'(bus.up_info), int'(ref_mem[10]));
    bus.start    = 1'b1;               // start+commit together: commit wins
    bus.commit   = 1'b1;
    bus.cur_info = 8'h4B;
    push_writes(10, 2, 8'h4B);
    tick();
    check("start_commit_busy", int'(bus.busy), 1);
    check("start_commit_nb_valid", int'(bus.nb_valid), 0);
    bus.cur_info = 8'hFF;              // start/commit held through WRITE and DONE
    tick();
    tick();
    check("ignored_done", int'(bus.done), 1);
    tick();
    bus.start  = 1'b0;
    bus.commit = 1'b0;
    check("start_in_done_busy", int'(bus.busy), 0);
    tick();
    check("start_in_done_busy_later", int'(bus.busy), 0);
    check("ignored_pending_writes", exp_q.size(), 0);
    check_ram();

    // Reset after the fifth write of a 16-wide PU
    start_pu(0, 16, int'(ref_mem[0]), int'(ref_mem[16]), 1);
    bus.commit   = 1'b1;
    bus.cur_info = 8'h11;
    push_writes(0, 5, 8'h11);
    tick();
    bus.commit = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    #1;
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_state", int'(dbg_state), 0);
    check("midrst_ram_bus", int'({bus.ram_en, bus.ram_we, bus.ram_dpra, bus.ram_d}), 0);
    check("midrst_outputs", int'({bus.nb_valid, bus.up_info, bus.upright_info, bus.upright_avail, bus.done}), 0);
    tick();
    rst = 1'b0;
    check("midrst_pending_writes", exp_q.size(), 0);
    check_ram();

    // Back-to-back PUs: the second reads what the first wrote
    run_pu(4, 2, 8'hA5, 8'h11, 8'h01, 1, 2);
    run_pu(4, 1, 8'hC3, 8'hA5, 8'hA5, 1, 1);

    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
